// File: rtl/fetch_dispatch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_dispatch_ctrl_pkg
// Brief    : Opcode constants, instruction field positions and FSM types
//            shared by the fetch/dispatch controller and the ALU-op sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_dispatch_ctrl_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_NOT  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_XNOR = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_SUBI = 4'h8;
  localparam logic [3:0] OP_NOP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int REGI_MSB = 11;
  localparam int REGI_LSB = 8;
  localparam int REGJ_MSB = 7;
  localparam int REGJ_LSB = 4;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_MEMWAIT = 3'd1,
    ST_DECODE  = 3'd2,
    ST_START   = 3'd3,
    ST_WAIT    = 3'd4,
    ST_ADVANCE = 3'd5,
    ST_HALT    = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    DEC_ALU     = 2'd0,
    DEC_NOP     = 2'd1,
    DEC_HALT    = 2'd2,
    DEC_ILLEGAL = 2'd3
  } dec_e;

  // Codes 9..D have no meaning and are reported as illegal.
  function automatic dec_e classify(input logic [3:0] op);
    dec_e r;
    if (op <= OP_SUBI) begin
      r = DEC_ALU;
    end else if (op == OP_NOP) begin
      r = DEC_NOP;
    end else if (op == OP_HALT) begin
      r = DEC_HALT;
    end else begin
      r = DEC_ILLEGAL;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_dispatch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_dispatch_ctrl_if
// Brief    : Instruction-memory read port plus ALU start/done handshake and
//            decoded instruction fields.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_dispatch_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              memRdEn;
  logic [ADDR_W-1:0] memAddr;
  logic [15:0]       memData;
  logic              memValid;
  logic              ALUstr;
  logic [3:0]        opCode;
  logic [3:0]        regI;
  logic [3:0]        regJ;
  logic [3:0]        imm;
  logic              aluDone;

  modport master (
    output memRdEn, memAddr, ALUstr, opCode, regI, regJ, imm,
    input  memData, memValid, aluDone
  );

  modport slave (
    input  memRdEn, memAddr, ALUstr, opCode, regI, regJ, imm,
    output memData, memValid, aluDone
  );
endinterface
`default_nettype wire

// File: rtl/fetch_dispatch_ctrl_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : wait_timer
// Brief    : Loadable down-counter; expired_o is high while the count is zero.
// Revision : 1.0 - initial release
// ============================================================================
module wait_timer #(
  parameter int WIDTH = 6
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load_i,
  input  wire logic [WIDTH-1:0] load_val_i,
  input  wire logic             en_i,
  output logic                  expired_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/fetch_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fetch_dispatch_ctrl
// Brief    : Fetches instructions, dispatches them to the ALU-op sequencer with
//            a one-cycle start pulse, and advances the PC on done.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_dispatch_ctrl
  import fetch_dispatch_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                TIMEOUT  = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  wire logic              clk,
  input  wire logic              reset,
  fetch_dispatch_ctrl_if.master  bus,
  output logic [ADDR_W-1:0]      pc,
  output logic                   halted,
  output logic                   err
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // Loaded in START; reaching zero marks the last WAIT cycle (TIMEOUT-1 WAITs).
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 2);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic              err_q, err_d;
  logic              memrd_q, memrd_d;
  logic              tmr_load, tmr_en, tmr_expired;

  wait_timer #(
    .WIDTH (TW)
  ) u_wait_timer (
    .clk        (clk),
    .rst        (reset),
    .load_i     (tmr_load),
    .load_val_i (TMR_LOAD),
    .en_i       (tmr_en),
    .expired_o  (tmr_expired)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    err_d    = err_q;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        state_d = ST_MEMWAIT;
      end
      ST_MEMWAIT: begin
        if (bus.memValid == 1'b1) begin
          ir_d    = bus.memData;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        unique case (classify(ir_q[OPC_MSB:OPC_LSB]))
          DEC_ALU:  state_d = ST_START;
          DEC_NOP:  state_d = ST_ADVANCE;
          DEC_HALT: state_d = ST_HALT;
          default: begin
            err_d   = 1'b1;
            state_d = ST_ADVANCE;
          end
        endcase
      end
      ST_START: begin
        tmr_load = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        // A done arriving in the final counted cycle still completes normally.
        if (bus.aluDone == 1'b1) begin
          state_d = ST_ADVANCE;
        end else if (tmr_expired) begin
          err_d   = 1'b1;
          state_d = ST_HALT;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_ADVANCE: begin
        pc_d    = pc_q + ADDR_W'(1);
        state_d = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
    memrd_d = (state_d == ST_MEMWAIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      err_q   <= 1'b0;
      memrd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
      memrd_q <= memrd_d;
    end
  end

  assign bus.memRdEn = memrd_q;
  assign bus.memAddr = pc_q;
  assign bus.ALUstr  = (state_q == ST_START);
  assign bus.opCode  = ir_q[OPC_MSB:OPC_LSB];
  assign bus.regI    = ir_q[REGI_MSB:REGI_LSB];
  assign bus.regJ    = ir_q[REGJ_MSB:REGJ_LSB];
  assign bus.imm     = ir_q[IMM_MSB:IMM_LSB];

  assign pc     = pc_q;
  assign halted = (state_q == ST_HALT);
  assign err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_dispatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_dispatch_ctrl
// Brief    : Directed self-checking bench for fetch_dispatch_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_dispatch_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_dispatch_ctrl_if #(.ADDR_W(8)) bus0 ();
  fetch_dispatch_ctrl_if #(.ADDR_W(2)) bus1 ();

  logic [7:0] pc0;
  logic       halted0, err0;
  logic [1:0] pc1;
  logic       halted1, err1;

  fetch_dispatch_ctrl #(.ADDR_W(8), .TIMEOUT(64), .RESET_PC(8'd0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0), .pc(pc0), .halted(halted0), .err(err0)
  );

  fetch_dispatch_ctrl #(.ADDR_W(2), .TIMEOUT(4), .RESET_PC(2'd1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .pc(pc1), .halted(halted1), .err(err1)
  );

  int checks = 0;
  int failures = 0;
  int str0 = 0;

  always @(negedge clk) if (bus0.ALUstr === 1'b1) str0++;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus0.memValid = 1'b0; bus0.memData = 16'h0; bus0.aluDone = 1'b0;
    bus1.memValid = 1'b0; bus1.memData = 16'h0; bus1.aluDone = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Waits for the read request, checks its address, answers after 'delay' cycles.
  task automatic serve0(input logic [7:0] addr, input logic [15:0] data, input int delay);
    int n = 0;
    while (bus0.memRdEn !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (bus0.memRdEn !== 1'b1) begin
      failures++; $display("FAIL fetch_req: memRdEn=%b required 1 (addr %0d)", bus0.memRdEn, addr);
    end
    checks++;
    if (bus0.memAddr !== addr) begin
      failures++; $display("FAIL fetch_addr: memAddr=%0d required %0d", bus0.memAddr, addr);
    end
    repeat (delay) @(negedge clk);
    bus0.memValid = 1'b1; bus0.memData = data;
    @(negedge clk);
    bus0.memValid = 1'b0; bus0.memData = 16'hDEAD;
  endtask

  task automatic wait_str0();
    int n = 0;
    while (bus0.ALUstr !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (bus0.ALUstr !== 1'b1) begin
      failures++; $display("FAIL alustr_seen: ALUstr=%b required 1", bus0.ALUstr);
    end
  endtask

  // Done is sampled in WAIT cycle 'done_delay' after the start pulse.
  task automatic alu0(input int done_delay);
    wait_str0();
    repeat (done_delay) @(negedge clk);
    bus0.aluDone = 1'b1;
    @(negedge clk);
    bus0.aluDone = 1'b0;
  endtask

  task automatic wait_rd0();
    int n = 0;
    while (bus0.memRdEn !== 1'b1 && n < 20) begin @(negedge clk); n++; end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({pc0, bus0.memRdEn, bus0.ALUstr, halted0, err0} !== 12'h000) begin
      failures++; $display("FAIL reset_ctrl: pc=%0d rd=%b str=%b halted=%b err=%b required 0/0/0/0/0",
                           pc0, bus0.memRdEn, bus0.ALUstr, halted0, err0);
    end
    checks++;
    if ({bus0.opCode, bus0.regI, bus0.regJ, bus0.imm} !== 16'h0000) begin
      failures++; $display("FAIL reset_ir: fields=%h required 0000",
                           {bus0.opCode, bus0.regI, bus0.regJ, bus0.imm});
    end
    checks++;
    if (pc1 !== 2'd1 || bus1.memRdEn !== 1'b0) begin
      failures++; $display("FAIL reset_pc1: pc=%0d rd=%b required 1/0", pc1, bus1.memRdEn);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    int s;
    do_reset();
    s = str0;
    serve0(8'd0, 16'h7125, 1);
    checks++;
    if ({bus0.opCode, bus0.regI, bus0.regJ, bus0.imm} !== 16'h7125) begin
      failures++; $display("FAIL single_fields: fields=%h required 7125",
                           {bus0.opCode, bus0.regI, bus0.regJ, bus0.imm});
    end
    wait_str0();
    @(negedge clk);
    checks++;
    if (bus0.ALUstr !== 1'b0) begin
      failures++; $display("FAIL single_pulse_width: ALUstr=%b required 0", bus0.ALUstr);
    end
    repeat (9) @(negedge clk);
    bus0.aluDone = 1'b1;
    @(negedge clk);
    bus0.aluDone = 1'b0;
    checks++;
    if (bus0.opCode !== 4'h7 || pc0 !== 8'd0) begin
      failures++; $display("FAIL single_hold: opCode=%h pc=%0d required 7/0", bus0.opCode, pc0);
    end
    @(negedge clk);
    checks++;
    if (pc0 !== 8'd1) begin
      failures++; $display("FAIL single_pc: pc=%0d required 1", pc0);
    end
    wait_rd0();
    checks++;
    if (bus0.memAddr !== 8'd1 || str0 - s !== 1) begin
      failures++; $display("FAIL single_next: addr=%0d pulses=%0d required 1/1", bus0.memAddr, str0 - s);
    end
  endtask

  task automatic test_three();
    int s;
    do_reset();
    s = str0;
    serve0(8'd0, 16'h0123, 0); alu0(2);
    serve0(8'd1, 16'h2450, 3); alu0(1);
    serve0(8'd2, 16'h8673, 1);
    checks++;
    if (bus0.imm !== 4'h3 || bus0.regI !== 4'h6) begin
      failures++; $display("FAIL three_subi_fields: regI=%h imm=%h required 6/3", bus0.regI, bus0.imm);
    end
    alu0(4);
    @(negedge clk);
    checks++;
    if (pc0 !== 8'd3 || err0 !== 1'b0 || str0 - s !== 3) begin
      failures++; $display("FAIL three_end: pc=%0d err=%b pulses=%0d required 3/0/3", pc0, err0, str0 - s);
    end
  endtask

  task automatic test_illegal();
    int s;
    do_reset();
    s = str0;
    serve0(8'd0, 16'hA000, 0);
    serve0(8'd1, 16'hE000, 2);
    checks++;
    if (err0 !== 1'b1) begin
      failures++; $display("FAIL illegal_err: err=%b required 1", err0);
    end
    wait_rd0();
    checks++;
    if (bus0.memAddr !== 8'd2 || pc0 !== 8'd2) begin
      failures++; $display("FAIL illegal_pc: addr=%0d pc=%0d required 2/2", bus0.memAddr, pc0);
    end
    checks++;
    if (err0 !== 1'b1 || halted0 !== 1'b0 || str0 - s !== 0) begin
      failures++; $display("FAIL illegal_sticky: err=%b halted=%b pulses=%0d required 1/0/0",
                           err0, halted0, str0 - s);
    end
  endtask

  task automatic test_timeout();
    int s;
    int rd_seen = 0;
    do_reset();
    s = str0;
    serve0(8'd0, 16'h3456, 0);
    wait_str0();
    bus0.aluDone = 1'bz;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (k == 32) bus0.aluDone = 1'b0;
      if (k == 63) begin
        checks++;
        if (halted0 !== 1'b0 || err0 !== 1'b0) begin
          failures++; $display("FAIL timeout_early: halted=%b err=%b required 0/0 at 63", halted0, err0);
        end
      end
      if (k == 64) begin
        checks++;
        if (halted0 !== 1'b1 || err0 !== 1'b1) begin
          failures++; $display("FAIL timeout_halt: halted=%b err=%b required 1/1 at 64", halted0, err0);
        end
      end
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus0.memRdEn !== 1'b0 || bus0.ALUstr !== 1'b0) rd_seen++;
    end
    checks++;
    if (rd_seen != 0 || halted0 !== 1'b1 || str0 - s !== 1) begin
      failures++; $display("FAIL timeout_quiet: active=%0d halted=%b pulses=%0d required 0/1/1",
                           rd_seen, halted0, str0 - s);
    end
  endtask

  task automatic test_done_boundary();
    do_reset();
    serve0(8'd0, 16'h1111, 0);
    alu0(63);
    checks++;
    if (halted0 !== 1'b0 || err0 !== 1'b0) begin
      failures++; $display("FAIL boundary_done: halted=%b err=%b required 0/0", halted0, err0);
    end
    wait_rd0();
    checks++;
    if (bus0.memAddr !== 8'd1) begin
      failures++; $display("FAIL boundary_next: addr=%0d required 1", bus0.memAddr);
    end
  endtask

  task automatic test_wrap();
    logic [1:0] exp;
    int n;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      exp = 2'(1 + i);
      n = 0;
      while (bus1.memRdEn !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (bus1.memRdEn !== 1'b1 || bus1.memAddr !== exp) begin
        failures++; $display("FAIL wrap_addr%0d: rd=%b addr=%0d required 1/%0d", i, bus1.memRdEn, bus1.memAddr, exp);
      end
      if (i < 4) begin
        bus1.memValid = 1'b1; bus1.memData = 16'hE000;
        @(negedge clk);
        bus1.memValid = 1'b0;
      end
    end
    checks++;
    if (pc1 !== 2'd1 || err1 !== 1'b0 || halted1 !== 1'b0) begin
      failures++; $display("FAIL wrap_end: pc=%0d err=%b halted=%b required 1/0/0", pc1, err1, halted1);
    end
  endtask

  task automatic test_reset_abort();
    int s;
    do_reset();
    s = str0;
    serve0(8'd0, 16'hE000, 0);
    serve0(8'd1, 16'h0345, 0);
    wait_str0();
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({pc0, bus0.memRdEn, bus0.ALUstr, halted0, err0, bus0.opCode} !== 16'h0000) begin
      failures++; $display("FAIL abort_wait: pc=%0d rd=%b str=%b halted=%b err=%b op=%h required all 0",
                           pc0, bus0.memRdEn, bus0.ALUstr, halted0, err0, bus0.opCode);
    end
    @(negedge clk);
    reset = 1'b0;
    wait_rd0();
    checks++;
    if (bus0.memAddr !== 8'd0 || str0 - s !== 1) begin
      failures++; $display("FAIL abort_refetch: addr=%0d pulses=%0d required 0/1", bus0.memAddr, str0 - s);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (bus0.memRdEn !== 1'b0) begin
      failures++; $display("FAIL abort_memwait: memRdEn=%b required 0", bus0.memRdEn);
    end
    @(negedge clk);
    reset = 1'b0;
    serve0(8'd0, 16'hF000, 0);
    repeat (4) @(negedge clk);
    checks++;
    if (halted0 !== 1'b1 || bus0.memRdEn !== 1'b0 || err0 !== 1'b0 || str0 - s !== 1) begin
      failures++; $display("FAIL halt_instr: halted=%b rd=%b err=%b pulses=%0d required 1/0/0/1",
                           halted0, bus0.memRdEn, err0, str0 - s);
    end
  endtask

  initial begin
    bus0.memValid = 1'b0; bus0.memData = 16'h0; bus0.aluDone = 1'b0;
    bus1.memValid = 1'b0; bus1.memData = 16'h0; bus1.aluDone = 1'b0;
    test_reset();
    test_single();
    test_three();
    test_illegal();
    test_timeout();
    test_done_boundary();
    test_wrap();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/fetch_dispatch_ctrl.md
Name: fetch_dispatch_ctrl

Overview:
Instruction fetch/dispatch controller. It is the initiator side of the ALU start/done handshake. It fetches 16-bit instructions from instruction memory, latches them into the IR, and exposes opcode and register fields to the ALU-op sequencer. It issues a one-cycle start pulse, waits for the sequencer's done, then advances the PC. A done timeout and halt/illegal-opcode handling stop the core cleanly.

Parameters:
ADDR_W, 8, instruction address / PC width
TIMEOUT, 64, max cycles to wait for aluDone before flagging error (>=2)
RESET_PC, 0, PC value after reset

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
memRdEn  output  1  instruction read request, held until memValid
memAddr  output  ADDR_W  fetch address (= PC)
memData  input  16  instruction word, valid when memValid=1
memValid  input  1  read data valid; sampled only while memRdEn=1
ALUstr  output  1  one-cycle start pulse to the ALU-op sequencer
opCode  output  4  IR[15:12]
regI  output  4  IR[11:8], destination/first source
regJ  output  4  IR[7:4], second source
imm  output  4  IR[3:0], immediate for ADDI/SUBI
aluDone  input  1  sequencer done; only a sampled 1 counts (z/x/0 = not done)
pc  output  ADDR_W  current PC
halted  output  1  high in HALT state
err  output  1  sticky; set on illegal opcode or timeout

Behaviour:
- Reset (async) values: state=FETCH; pc=RESET_PC; IR=0; memRdEn=0; ALUstr=0; halted=0; err=0; timeout counter=0.
- A reset mid-operation aborts immediately. No ALUstr is issued until a new fetch completes.
- Opcodes: ADD=0, SUB=1, NOT=2, AND=3, OR=4, XOR=5, XNOR=6, ADDI=7, SUBI=8, NOP=4'hE, HALT=4'hF. Codes 9..D are illegal.
- FSM states are FETCH, MEMWAIT, DECODE, START, WAIT, ADVANCE, HALT.
- FETCH: assert memRdEn, memAddr=pc; go to MEMWAIT.
- MEMWAIT: hold memRdEn. When memValid=1, load IR<=memData, drop memRdEn next cycle, go to DECODE.
  - memValid in the same cycle as the request counts, so minimum fetch latency is 2 cycles.
- DECODE:
  - opcode 0..8 -> START.
  - NOP -> ADVANCE.
  - HALT -> HALT.
  - illegal -> set err, go to ADVANCE (the instruction is skipped).
- START: ALUstr=1 for exactly this one cycle; clear counter; go to WAIT.
- WAIT: ALUstr=0.
  - aluDone==1 -> ADVANCE.
  - Otherwise increment the counter. When counter==TIMEOUT-1 without done: set err, go to HALT.
  - Done in the same cycle as the last count: done wins.
- ADVANCE: pc<=pc+1, wrapping modulo 2^ADDR_W (no error on wrap); go to FETCH.
- HALT: halted=1, memRdEn=0, ALUstr=0. Remain here until reset.
- IR, and therefore opCode/regI/regJ/imm, is stable from DECODE through ADVANCE. The sequencer reads the fields throughout its operation.
- aluDone outside WAIT is ignored.
- memValid outside MEMWAIT is ignored.
- ALUstr is never asserted twice per instruction. This prevents the sequencer from re-triggering when it returns to idle.
- Throughput: 1 instruction per (fetch latency + 2 + ALU latency + 1) cycles; no overlap.

Decomposition:
- Shared package/header `cpu_defs`: opcode constants (ADD..SUBI, NOP, HALT) and instruction field bit positions. Both this block and the ALU-op sequencer include it.
- Sub-module `wait_timer`: loadable down-counter with expire flag, used for the done timeout.
- The FSM and PC/IR registers stay in the top module.

Test Plan:
- Reset, mem returns 16'h7125 one cycle after request, done 10 cycles after ALUstr -> opCode=7, regI=1, regJ=2, imm=5; single ALUstr pulse; pc 0->1; next fetch at addr 1.
- Three instructions ADD, NOT, SUBI with memValid delays 0/3/1 -> exactly 3 ALUstr pulses; pc ends at 3; err=0.
- Instruction 16'hA000 (illegal) followed by 16'hE000 (NOP) -> err=1 sticky, no ALUstr for either; pc advances past both.
- aluDone held 0 (and driven z) after ALUstr -> err=1 and halted=1 exactly TIMEOUT cycles after the pulse; no further memRdEn.
- ADDR_W=2, four NOPs -> pc wraps 3->0 and fetch continues at addr 0.
- Assert reset in WAIT and in MEMWAIT -> all outputs return to reset values asynchronously; after deassert, a fetch at RESET_PC with no stale ALUstr. Then a HALT instruction (16'hF000) -> halted=1, no ALUstr.
